// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the cache-to-memory arbiter: FSM states,
// owner codes, block/word sizes and the round-robin pick rule.
package mem_arbiter_pkg;

    localparam int WORD_SIZE       = 32;
    localparam int BLOCK_SIZE      = 256;
    localparam int MEM_LATENCY_DEF = 4;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_WAIT   = 2'd2,
        ARB_DONE   = 2'd3
    } arb_state_t;

    typedef enum logic {
        ARB_I = 1'b0,
        ARB_D = 1'b1
    } arb_owner_t;

    // On a tie the requester that was not served last wins.
    function automatic arb_owner_t pick_owner(input logic i_req, input logic d_req,
                                              input arb_owner_t last_grant);
        arb_owner_t winner;
        if (i_req && d_req)
            winner = (last_grant == ARB_I) ? ARB_D : ARB_I;
        else if (d_req)
            winner = ARB_D;
        else
            winner = ARB_I;
        return winner;
    endfunction

endpackage

// File: rtl/mem_arbiter_lat.sv
// Loadable down-counter that times the fixed memory latency; last marks
// the cycle in which read data is valid.
module mem_lat_counter #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic last
);
    localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= W'(MAX);
        else if (en && count != '0)
            count <= count - 1'b1;
    end

    assign last = (count == W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory block port between
// the icache refill path and the dcache refill/write-back path.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = WORD_SIZE,
    parameter int BLOCK_W     = BLOCK_SIZE,
    parameter int MEM_LATENCY = MEM_LATENCY_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_req,
    input  logic [ADDR_W-1:0]  i_addr,
    output logic               i_ready,
    output logic [BLOCK_W-1:0] i_rdata,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [ADDR_W-1:0]  d_addr,
    input  logic [BLOCK_W-1:0] d_wdata,
    output logic               d_ready,
    output logic [BLOCK_W-1:0] d_rdata,
    output logic               mem_en,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [BLOCK_W-1:0] mem_wdata,
    input  logic [BLOCK_W-1:0] mem_rdata,
    output logic               busy
);

    arb_state_t         state, state_next;
    arb_owner_t         owner, last_grant, grant;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [BLOCK_W-1:0] wdata_q;
    logic               cnt_load, cnt_en, cnt_last;

    assign grant     = pick_owner(i_req, d_req, last_grant);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    mem_lat_counter #(.MAX(MEM_LATENCY)) u_lat (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .en   (cnt_en),
        .last (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= ARB_IDLE;
        else
            state <= state_next;
    end

    // Every output is a decode of the state and latched registers, so a
    // request change never reaches the memory port in the same cycle.
    always_comb begin
        state_next = state;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        i_ready    = 1'b0;
        d_ready    = 1'b0;
        busy       = 1'b1;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;
        case (state)
            ARB_IDLE: begin
                busy = 1'b0;
                if (i_req || d_req)
                    state_next = ARB_ACCESS;
            end
            ARB_ACCESS: begin
                mem_en     = 1'b1;
                mem_we     = we_q;
                cnt_load   = 1'b1;
                state_next = ARB_WAIT;
            end
            ARB_WAIT: begin
                cnt_en = 1'b1;
                if (cnt_last)
                    state_next = ARB_DONE;
            end
            ARB_DONE: begin
                i_ready    = (owner == ARB_I);
                d_ready    = (owner == ARB_D);
                state_next = ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner      <= ARB_I;
            last_grant <= ARB_I;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            if (state == ARB_IDLE && (i_req || d_req)) begin
                owner   <= grant;
                we_q    <= (grant == ARB_D) && d_we;
                addr_q  <= (grant == ARB_D) ? d_addr : i_addr;
                wdata_q <= (grant == ARB_D) ? d_wdata : '0;
            end
            // Write-backs return nothing, so neither rdata register moves.
            if (state == ARB_WAIT && cnt_last && !we_q) begin
                if (owner == ARB_D)
                    d_rdata <= mem_rdata;
                else
                    i_rdata <= mem_rdata;
            end
            if (state == ARB_DONE)
                last_grant <= owner;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic against a transaction-level model of the arbiter and memory.
module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int BW  = 256;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] i_addr = '0, d_addr = '0;
    logic [BW-1:0] d_wdata = '0, mem_rdata = '0;
    logic          i_ready, d_ready, mem_en, mem_we, busy;
    logic [BW-1:0] i_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    logic          rst2 = 1'b1, i_req2 = 1'b0;
    logic [AW-1:0] i_addr2 = 32'h40;
    logic          d_req2 = 1'b0, d_we2 = 1'b0;
    logic [AW-1:0] d_addr2 = '0;
    logic [BW-1:0] d_wdata2 = '0, mem_rdata2 = '0;
    logic          i_ready2, d_ready2, mem_en2, mem_we2, busy2;
    logic [BW-1:0] i_rdata2, d_rdata2, mem_wdata2;
    logic [AW-1:0] mem_addr2;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .BLOCK_W(BW), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.ADDR_W(AW), .BLOCK_W(BW), .MEM_LATENCY(1)) dut_lat1 (
        .clk(clk), .rst(rst2),
        .i_req(i_req2), .i_addr(i_addr2), .i_ready(i_ready2), .i_rdata(i_rdata2),
        .d_req(d_req2), .d_we(d_we2), .d_addr(d_addr2), .d_wdata(d_wdata2),
        .d_ready(d_ready2), .d_rdata(d_rdata2),
        .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2),
        .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2), .busy(busy2)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: one transaction at a time, timed from the grant cycle.
    bit            m_active = 1'b0, m_owner = 1'b0, m_last = 1'b0, m_we = 1'b0;
    int            m_start = 0, m_next_sample = 0;
    logic [AW-1:0] m_addr = '0;
    logic [BW-1:0] m_wdata = '0, m_data = '0;
    logic [BW-1:0] exp_i_rdata = '0, exp_d_rdata = '0;
    logic [BW-1:0] refmem [logic [AW-1:0]];

    // Behavioural memory answering the DUT's own port.
    bit            dev_pend = 1'b0;
    int            dev_due = 0;
    logic [BW-1:0] dev_data = '0;
    logic [BW-1:0] devmem [logic [AW-1:0]];

    int en_q[$], en_we_q[$], i_rdy_q[$], d_rdy_q[$], rdy_who[$], rdy_cyc[$];

    function automatic logic [BW-1:0] memInit(input logic [AW-1:0] a);
        if (a == 32'h100)
            return {32{8'hAA}};
        return {8{a * 32'h9E37_79B9 + 32'h0000_1234}};
    endfunction

    function automatic logic [BW-1:0] refRead(input logic [AW-1:0] a);
        if (refmem.exists(a))
            return refmem[a];
        return memInit(a);
    endfunction

    function automatic logic [BW-1:0] devRead(input logic [AW-1:0] a);
        if (devmem.exists(a))
            return devmem[a];
        return memInit(a);
    endfunction

    function automatic logic [BW-1:0] rand256();
        logic [BW-1:0] r;
        for (int i = 0; i < 8; i++)
            r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [AW-1:0] randAddr();
        return AW'($urandom_range(0, 15) << 6);
    endfunction

    function automatic int qAt(input int q[$], input int i);
        if (i < q.size())
            return q[i];
        return -999;
    endfunction

    task automatic checkOutput(input string tag, input logic [BW-1:0] got,
                               input logic [BW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clearLog();
        en_q.delete(); en_we_q.delete(); i_rdy_q.delete();
        d_rdy_q.delete(); rdy_who.delete(); rdy_cyc.delete();
    endtask

    // Advance one cycle, compare outputs with the model, then serve memory.
    task automatic tick();
        bit exp_rdy, exp_en;
        @(negedge clk);
        cyc++;
        exp_rdy = m_active && (cyc == m_start + LAT + 2);
        exp_en  = m_active && (cyc == m_start + 1);
        if (exp_rdy && !m_we) begin
            if (m_owner) exp_d_rdata = m_data;
            else         exp_i_rdata = m_data;
        end
        checkOutput("busy",    BW'(busy),    BW'(m_active && cyc > m_start));
        checkOutput("mem_en",  BW'(mem_en),  BW'(exp_en));
        checkOutput("i_ready", BW'(i_ready), BW'(exp_rdy && !m_owner));
        checkOutput("d_ready", BW'(d_ready), BW'(exp_rdy && m_owner));
        checkOutput("i_rdata", i_rdata, exp_i_rdata);
        checkOutput("d_rdata", d_rdata, exp_d_rdata);
        if (exp_en) begin
            checkOutput("mem_addr", BW'(mem_addr), BW'(m_addr));
            checkOutput("mem_we",   BW'(mem_we),   BW'(m_we));
            if (m_we)
                checkOutput("mem_wdata", mem_wdata, m_wdata);
        end
        if (exp_rdy)
            m_active = 1'b0;

        if (mem_en) begin en_q.push_back(cyc); en_we_q.push_back(int'(mem_we)); end
        if (i_ready) begin i_rdy_q.push_back(cyc); rdy_who.push_back(0); rdy_cyc.push_back(cyc); end
        if (d_ready) begin d_rdy_q.push_back(cyc); rdy_who.push_back(1); rdy_cyc.push_back(cyc); end

        if (mem_en) begin
            if (mem_we) begin
                devmem[mem_addr] = mem_wdata;
            end else begin
                dev_pend = 1'b1;
                dev_due  = cyc + LAT;
                dev_data = devRead(mem_addr);
            end
        end
        if (dev_pend && dev_due == cyc) begin
            mem_rdata = dev_data;
            dev_pend  = 1'b0;
        end else begin
            mem_rdata = rand256();
        end
    endtask

    // Arbitration decision for the inputs now applied in this cycle.
    task automatic decide();
        if (rst) begin
            m_active      = 1'b0;
            m_last        = 1'b0;
            exp_i_rdata   = '0;
            exp_d_rdata   = '0;
            m_next_sample = cyc + 1;
        end else if (!m_active && cyc >= m_next_sample && (i_req || d_req)) begin
            m_owner       = (i_req && d_req) ? !m_last : d_req;
            m_last        = m_owner;
            m_active      = 1'b1;
            m_start       = cyc;
            m_next_sample = cyc + LAT + 3;
            m_addr        = m_owner ? d_addr : i_addr;
            m_we          = m_owner && d_we;
            m_wdata       = d_wdata;
            if (m_we) refmem[m_addr] = d_wdata;
            else      m_data = refRead(m_addr);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit ir, input logic [AW-1:0] ia,
                                 input bit dr, input bit dwe, input logic [AW-1:0] da,
                                 input logic [BW-1:0] dw);
        tick();
        rst = r; i_req = ir; i_addr = ia;
        d_req = dr; d_we = dwe; d_addr = da; d_wdata = dw;
        decide();
    endtask

    initial begin
        int t0, en_at, rdy_at;
        bit prev_en;

        repeat (2) @(negedge clk);
        $display("[TB] starting mem_arbiter bench");

        // Single icache refill
        applyStimulus(1, 0, '0, 0, 0, '0, '0);
        applyStimulus(1, 0, '0, 0, 0, '0, '0);
        clearLog(); t0 = cyc + 1;
        for (int k = 0; k < 10; k++)
            applyStimulus(0, k < 6, 32'h100, 0, 0, '0, '0);
        checkOutput("single_en_cycle", BW'(qAt(en_q, 0) - t0), BW'(1));
        checkOutput("single_en_we", BW'(qAt(en_we_q, 0)), BW'(0));
        checkOutput("single_ready_cycle", BW'(qAt(i_rdy_q, 0) - t0), BW'(6));
        checkOutput("single_i_rdata", i_rdata, {32{8'hAA}});
        checkOutput("single_d_rdata", d_rdata, '0);

        // First tie after reset goes to dcache
        applyStimulus(1, 0, '0, 0, 0, '0, '0);
        applyStimulus(1, 0, '0, 0, 0, '0, '0);
        clearLog(); t0 = cyc + 1;
        for (int k = 0; k < 17; k++)
            applyStimulus(0, k < 13, 32'h140, k < 6, 0, 32'h180, '0);
        checkOutput("tie_d_ready", BW'(qAt(d_rdy_q, 0) - t0), BW'(6));
        checkOutput("tie_i_en", BW'(qAt(en_q, 1) - t0), BW'(8));
        checkOutput("tie_i_ready", BW'(qAt(i_rdy_q, 0) - t0), BW'(13));

        // Continuous contention alternates d, i, d, i every 7 cycles
        clearLog();
        for (int k = 0; k < 42; k++)
            applyStimulus(0, k < 27, 32'h140, k < 34, 0, 32'h180, '0);
        checkOutput("rr_who0", BW'(qAt(rdy_who, 0)), BW'(1));
        checkOutput("rr_who1", BW'(qAt(rdy_who, 1)), BW'(0));
        checkOutput("rr_who2", BW'(qAt(rdy_who, 2)), BW'(1));
        checkOutput("rr_who3", BW'(qAt(rdy_who, 3)), BW'(0));
        for (int n = 0; n < 3; n++)
            checkOutput("rr_spacing", BW'(qAt(rdy_cyc, n + 1) - qAt(rdy_cyc, n)), BW'(7));

        // dcache write-back
        clearLog(); t0 = cyc + 1;
        for (int k = 0; k < 10; k++)
            applyStimulus(0, 0, '0, k < 6, 1, 32'h200, {32{8'h55}});
        checkOutput("wb_en_cycle", BW'(qAt(en_q, 0) - t0), BW'(1));
        checkOutput("wb_en_we", BW'(qAt(en_we_q, 0)), BW'(1));
        checkOutput("wb_ready_cycle", BW'(qAt(d_rdy_q, 0) - t0), BW'(6));
        checkOutput("wb_d_rdata_kept", d_rdata, memInit(32'h180));

        // Reset in WAIT abandons the refill; the held request is re-run
        clearLog(); t0 = cyc + 1;
        for (int k = 0; k < 14; k++)
            applyStimulus(k == 3, k < 10, 32'h200, 0, 0, '0, '0);
        checkOutput("rstwait_en2", BW'(qAt(en_q, 1) - t0), BW'(5));
        checkOutput("rstwait_ready_count", BW'(i_rdy_q.size()), BW'(1));
        checkOutput("rstwait_ready_cycle", BW'(qAt(i_rdy_q, 0) - t0), BW'(10));
        checkOutput("rstwait_i_rdata", i_rdata, {32{8'h55}});

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            tick();
            if (i_req && i_ready) begin
                if ($urandom_range(0, 3) == 0) i_addr = randAddr();
                else                           i_req = 1'b0;
            end else if (!i_req && $urandom_range(0, 2) == 0) begin
                i_req  = 1'b1;
                i_addr = randAddr();
            end
            if (d_req && d_ready) begin
                if ($urandom_range(0, 3) == 0) begin
                    d_addr = randAddr(); d_we = 1'($urandom_range(0, 1)); d_wdata = rand256();
                end else begin
                    d_req = 1'b0;
                end
            end else if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_addr = randAddr();
                d_we = 1'($urandom_range(0, 1)); d_wdata = rand256();
            end
            rst = ($urandom_range(0, 149) == 0);
            decide();
        end
        applyStimulus(1, 0, '0, 0, 0, '0, '0);

        // Single-cycle-latency build
        @(negedge clk);
        rst2 = 1'b0;
        @(negedge clk);
        i_req2 = 1'b1;
        en_at = -1; rdy_at = -1; prev_en = 1'b0;
        for (int k = 1; k < 12; k++) begin
            @(negedge clk);
            if (mem_en2 && en_at < 0) begin
                en_at = k;
                checkOutput("lat1_mem_addr", BW'(mem_addr2), BW'(32'h40));
                checkOutput("lat1_mem_we", BW'(mem_we2), BW'(0));
            end
            if (i_ready2 && rdy_at < 0) begin
                rdy_at = k;
                i_req2 = 1'b0;
            end
            mem_rdata2 = prev_en ? {32{8'hC3}} : rand256();
            prev_en = mem_en2;
        end
        checkOutput("lat1_en_cycle", BW'(en_at), BW'(1));
        checkOutput("lat1_ready_cycle", BW'(rdy_at), BW'(3));
        checkOutput("lat1_i_rdata", i_rdata2, {32{8'hC3}});
        checkOutput("lat1_d_rdata", d_rdata2, '0);
        checkOutput("lat1_d_ready", BW'(d_ready2), BW'(0));
        checkOutput("lat1_idle", BW'(busy2), BW'(0));
        checkOutput("lat1_wdata", mem_wdata2, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences and shares the single backing-memory block port between the instruction-cache refill path and the data-cache refill/write-back path. Each cache raises a level request with a block address. The arbiter picks one requester round-robin, runs a fixed-latency memory access, captures the block, and returns a one-cycle ready pulse. It sits between `instcache`/data cache and main memory, and replaces the caches' fixed miss delay with a real, contended access.

## Interface
Parameters:
- `ADDR_W`, 32, block address width (`WORD_SIZE`)
- `BLOCK_W`, 256, block width (`BLOCK_SIZE`)
- `MEM_LATENCY`, 4, cycles from `mem_en` to valid `mem_rdata` (≥1)

Ports. Clock and reset first; one clock; reset is synchronous and active-high.
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `i_req`  in  1  icache refill request (level)
- `i_addr`  in  ADDR_W  icache block address
- `i_ready`  out  1  one-cycle completion pulse to icache
- `i_rdata`  out  BLOCK_W  block returned to icache
- `d_req`  in  1  dcache request (level)
- `d_we`  in  1  1 = write-back, 0 = refill
- `d_addr`  in  ADDR_W  dcache block address
- `d_wdata`  in  BLOCK_W  write-back data
- `d_ready`  out  1  one-cycle completion pulse to dcache
- `d_rdata`  out  BLOCK_W  block returned to dcache
- `mem_en`  out  1  memory access strobe, one cycle
- `mem_we`  out  1  memory write enable, valid with `mem_en`
- `mem_addr`  out  ADDR_W  memory address, held from ACCESS until IDLE
- `mem_wdata`  out  BLOCK_W  memory write data, held like `mem_addr`
- `mem_rdata`  in  BLOCK_W  memory read data
- `busy`  out  1  state ≠ IDLE

## Operation
- States are IDLE, ACCESS, WAIT and DONE.
- **IDLE:** sample `i_req`/`d_req`.
  - If exactly one is high, grant it.
  - If both are high, grant the requester not granted last. `last_grant` resets to icache, so dcache wins the first tie.
  - Latch the owner, address, `we` and `wdata` into internal registers, then go to ACCESS.
- **ACCESS:** `mem_en=1`, `mem_we`=latched `we`. Load latency counter with `MEM_LATENCY`, then go to WAIT.
- **WAIT:** decrement the counter each cycle.
  - When the counter reaches 1, capture `mem_rdata` into the owner's rdata register (refill only) and go to DONE.
  - A write leaves both rdata registers unchanged.
- **DONE:** assert the owner's ready for exactly one cycle, update `last_grant`, then go to IDLE. Requests are not sampled in DONE.
- **Requester contract:**
  - Hold req, address and `wdata` stable until ready is seen.
  - Deassert req in the cycle after ready, unless a new request is intended; a held req is treated as new.
- Only the owner's rdata register changes. The other requester's rdata register holds its value.
- **Reset at any point:** state → IDLE; `mem_en`, `mem_we`, both readies and `busy` → 0; `last_grant` → icache; both rdata registers and `mem_addr`/`mem_wdata` → 0.
  - The in-flight access is abandoned and no ready is issued.
  - A requester still holding req is re-arbitrated after reset.

## Timing
- Uncontended: req first high in IDLE at cycle 0; ACCESS at cycle 1; `mem_rdata` valid at cycle 1+`MEM_LATENCY`, captured at the end of that cycle; ready at cycle `MEM_LATENCY`+2. With default parameters this is cycle 6.
- rdata is registered and valid from the ready cycle until the next capture for that requester.
- Back-to-back: the earliest next ACCESS is 2 cycles after the previous DONE. Throughput is one block per `MEM_LATENCY`+3 cycles.
- The losing requester in a tie waits a full transaction and then wins. No starvation is possible with two requesters.
- All outputs are registered or decoded from state only. There are no combinational paths from req to `mem_*`.

## Structure
- Shared constants go in `define.v`: `MEM_LATENCY`, state encodings `ARB_IDLE`/`ARB_ACCESS`/`ARB_WAIT`/`ARB_DONE`, and owner codes `ARB_I`/`ARB_D`.
- Reuse the existing `BLOCK_SIZE`/`WORD_SIZE`.
- One sub-module is natural: `mem_lat_counter`, a loadable down-counter with load, enable and a `last` flag. It is sized `$clog2(MEM_LATENCY+1)`.
- The FSM, round-robin bit and capture registers stay in `mem_arbiter`.

## Test plan
- Single icache refill: `i_req=1`, `i_addr=0x100`, memory returns 0xAA…AA → `mem_en` at cycle 1 with `mem_addr=0x100`, `mem_we=0`; `i_ready` only at cycle 6; `i_rdata=0xAA…AA`; `d_rdata` stays 0.
- Simultaneous first requests after reset: `i_req` and `d_req` both high at cycle 0 → dcache granted first (`d_ready` at cycle 6); icache `mem_en` at cycle 8; `i_ready` at cycle 13.
- Repeated contention: both reqs held continuously → ready alternates d, i, d, i, spaced 7 cycles apart.
- Write-back: `d_req=1`, `d_we=1`, `d_addr=0x200`, `d_wdata=0x55…55` → `mem_en=1`, `mem_we=1`, `mem_addr=0x200`, `mem_wdata=0x55…55`; `d_ready` at cycle 6; `d_rdata` unchanged.
- Reset mid-WAIT: `rst` pulsed at cycle 3 of an icache refill → no `i_ready`, `busy=0` next cycle, `mem_en=0`. With `i_req` still high, a new `mem_en` occurs one cycle after the last reset cycle and ready comes 5 cycles later.
- `MEM_LATENCY=1` build: uncontended ready at cycle 3; data captured correctly.
